// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit channel.
//   PAR_*       : parity mode encodings carried on cfg_par
//   tx_state_t  : transmit framer states
//   OVERSAMPLE  : baud_pulses per bit time
//   TICK_W      : width of the per-bit pulse down-counter (covers a double stop bit)
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int TICK_W     = $clog2(2 * OVERSAMPLE);

   localparam logic [1:0] PAR_NONE  = 2'd0;
   localparam logic [1:0] PAR_ODD   = 2'd1;
   localparam logic [1:0] PAR_EVEN  = 2'd2;
   localparam logic [1:0] PAR_STICK = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_fifo_sync.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst   : clock, async active-high reset
//   wr, din    : push request and data
//   rd         : pop request (ignored when empty)
//   clr        : synchronous flush, wins over wr and rd
//   dout       : head entry, valid while !empty
//   count      : occupancy, full, empty
//   overflow   : one-cycle pulse after a write dropped because the FIFO was full
module uart_fifo_sync #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr,
   input  logic [W-1:0]               din,
   input  logic                       rd,
   input  logic                       clr,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign pop   = rd && !empty && !clr;
   // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken.
   assign push  = wr && !clr && (!full || pop);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= wr && !clr && full && !pop;
         if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo_gen.sv
// UART transmit channel: transmit FIFO, runtime baud divisor, runtime character
// format (5..MAX_DATA_W data bits, parity, 1/2 stop bits) and break.
//   clk, rst               : clock, async active-high reset
//   wr, din, fifo_clr      : FIFO push / flush
//   cfg_div                : baud divisor (0 stops the generator)
//   cfg_len                : data bits minus 1 (clamped to 4..MAX_DATA_W-1)
//   cfg_par, cfg_stop2     : parity mode, two stop bits
//   cfg_brk                : force tx low
//   tx                     : serial line, idle high
//   baud_pulse             : 16x oversample tick
//   sreg_empty             : no frame in progress
//   fifo_empty/full/count  : FIFO status
//   overflow               : dropped-write pulse
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line high; pop and latch the next character on a baud_pulse
// ST_START  | start bit, tx low
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit precomputed at pop time
// ST_STOP   | stop bit(s), tx high, then back to idle
module uart_tx_fifo_gen
   import uart_pkg::*;
#(
   parameter int MAX_DATA_W = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr,
   input  logic [MAX_DATA_W-1:0]             din,
   input  logic                              fifo_clr,
   input  logic [DIV_W-1:0]                  cfg_div,
   input  logic [$clog2(MAX_DATA_W)-1:0]     cfg_len,
   input  logic [1:0]                        cfg_par,
   input  logic                              cfg_stop2,
   input  logic                              cfg_brk,
   output logic                              tx,
   output logic                              baud_pulse,
   output logic                              sreg_empty,
   output logic                              fifo_empty,
   output logic                              fifo_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              overflow
);

   localparam int                LEN_W    = $clog2(MAX_DATA_W);
   localparam logic [TICK_W-1:0] BIT_LOAD = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TWO_LOAD = TICK_W'(2 * OVERSAMPLE - 1);

   logic [DIV_W-1:0]      baud_cnt;
   logic                  fifo_rd;
   logic [MAX_DATA_W-1:0] fifo_dout;

   tx_state_t             state, state_nxt;
   logic [TICK_W-1:0]     tick, tick_nxt;
   logic [LEN_W-1:0]      bit_cnt, bit_cnt_nxt;
   logic [MAX_DATA_W-1:0] shreg, shreg_nxt;
   logic                  has_par, has_par_nxt;
   logic                  stop2, stop2_nxt;
   logic                  par_bit, par_bit_nxt;

   logic [LEN_W-1:0]      len_eff;
   logic [MAX_DATA_W-1:0] masked;
   logic                  par_calc;
   logic [TICK_W-1:0]     stop_load;
   logic                  fsm_tx;

   uart_fifo_sync #(
      .W     (MAX_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .din      (din),
      .rd       (fifo_rd),
      .clr      (fifo_clr),
      .dout     (fifo_dout),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .overflow (overflow)
   );

   // A counter left above a freshly lowered divisor restarts at 0 without a pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt   <= '0;
         baud_pulse <= 1'b0;
      end else if (cfg_div == '0) begin
         baud_cnt   <= '0;
         baud_pulse <= 1'b0;
      end else if (baud_cnt == cfg_div - DIV_W'(1)) begin
         baud_cnt   <= '0;
         baud_pulse <= 1'b1;
      end else if (baud_cnt >= cfg_div) begin
         baud_cnt   <= '0;
         baud_pulse <= 1'b0;
      end else begin
         baud_cnt   <= baud_cnt + DIV_W'(1);
         baud_pulse <= 1'b0;
      end
   end

   always_comb begin
      len_eff = cfg_len;
      if (cfg_len < LEN_W'(4))
         len_eff = LEN_W'(4);
      else if (int'(cfg_len) > MAX_DATA_W - 1)
         len_eff = LEN_W'(MAX_DATA_W - 1);
   end

   // Parity covers only the bits that will actually be sent.
   always_comb begin
      masked = '0;
      for (int i = 0; i < MAX_DATA_W; i++)
         if (i <= int'(len_eff)) masked[i] = fifo_dout[i];
      case (cfg_par)
         PAR_ODD:   par_calc = ~^masked;
         PAR_EVEN:  par_calc = ^masked;
         PAR_STICK: par_calc = 1'b1;
         default:   par_calc = 1'b0;
      endcase
   end

   assign stop_load = stop2 ? TWO_LOAD : BIT_LOAD;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         tick    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         has_par <= 1'b0;
         stop2   <= 1'b0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_nxt;
         tick    <= tick_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         has_par <= has_par_nxt;
         stop2   <= stop2_nxt;
         par_bit <= par_bit_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      tick_nxt    = tick;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      has_par_nxt = has_par;
      stop2_nxt   = stop2;
      par_bit_nxt = par_bit;
      fifo_rd     = 1'b0;
      fsm_tx      = 1'b1;

      unique case (state)
         ST_IDLE: begin
            // A flush in the same cycle cancels the pop, so nothing is started.
            if (baud_pulse && !fifo_empty && !fifo_clr) begin
               fifo_rd     = 1'b1;
               state_nxt   = ST_START;
               tick_nxt    = BIT_LOAD;
               shreg_nxt   = fifo_dout;
               bit_cnt_nxt = len_eff;
               has_par_nxt = (cfg_par != PAR_NONE);
               stop2_nxt   = cfg_stop2;
               par_bit_nxt = par_calc;
            end
         end

         ST_START: begin
            fsm_tx = 1'b0;
            if (baud_pulse) begin
               if (tick == '0) begin
                  state_nxt = ST_DATA;
                  tick_nxt  = BIT_LOAD;
               end else begin
                  tick_nxt = tick - TICK_W'(1);
               end
            end
         end

         ST_DATA: begin
            fsm_tx = shreg[0];
            if (baud_pulse) begin
               if (tick == '0) begin
                  shreg_nxt = shreg >> 1;
                  if (bit_cnt == '0) begin
                     if (has_par) begin
                        state_nxt = ST_PARITY;
                        tick_nxt  = BIT_LOAD;
                     end else begin
                        state_nxt = ST_STOP;
                        tick_nxt  = stop_load;
                     end
                  end else begin
                     bit_cnt_nxt = bit_cnt - LEN_W'(1);
                     tick_nxt    = BIT_LOAD;
                  end
               end else begin
                  tick_nxt = tick - TICK_W'(1);
               end
            end
         end

         ST_PARITY: begin
            fsm_tx = par_bit;
            if (baud_pulse) begin
               if (tick == '0) begin
                  state_nxt = ST_STOP;
                  tick_nxt  = stop_load;
               end else begin
                  tick_nxt = tick - TICK_W'(1);
               end
            end
         end

         ST_STOP: begin
            fsm_tx = 1'b1;
            if (baud_pulse) begin
               if (tick == '0) state_nxt = ST_IDLE;
               else            tick_nxt  = tick - TICK_W'(1);
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   assign sreg_empty = (state == ST_IDLE);
   // Break overrides the line only; the framer keeps its own timing underneath.
   assign tx = cfg_brk ? 1'b0 : fsm_tx;

endmodule

// File: tb/tb_uart_tx_fifo_gen.sv
module tb_uart_tx_fifo_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        fifo_clr = 1'b0;
   logic [15:0] cfg_div = 16'd1;
   logic [2:0]  cfg_len = 3'd7;
   logic [1:0]  cfg_par = 2'd0;
   logic        cfg_stop2 = 1'b0;
   logic        cfg_brk = 1'b0;
   logic        tx, baud_pulse, sreg_empty, fifo_empty, fifo_full, overflow;
   logic [4:0]  fifo_count;

   uart_tx_fifo_gen #(.MAX_DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
      .clk(clk), .rst(rst), .wr(wr), .din(din), .fifo_clr(fifo_clr),
      .cfg_div(cfg_div), .cfg_len(cfg_len), .cfg_par(cfg_par),
      .cfg_stop2(cfg_stop2), .cfg_brk(cfg_brk), .tx(tx),
      .baud_pulse(baud_pulse), .sreg_empty(sreg_empty),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // One expected frame: line levels per bit (index 0 = start bit), bit count,
   // clocks per bit, expected idle cycles before it (-1 = unchecked), or a
   // frame that is expected to be cut short by reset.
   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          bclk;
      int          gap;
      bit          abort;
   } exp_t;

   exp_t exp_q[$];
   bit   mon_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t mk_exp(input logic [15:0] bits, input int nbits, input int div,
                                   input int gap, input bit abort);
      exp_t e;
      e.bits  = bits;
      e.nbits = nbits;
      e.bclk  = 16 * div;
      e.gap   = gap;
      e.abort = abort;
      return e;
   endfunction

   // Monitor: a frame starts when sreg_empty falls; every bit is sampled on each
   // of its clocks and must hold one level, and sreg_empty must rise right after.
   initial begin : monitor
      exp_t        e;
      logic        prev_se;
      logic        first;
      logic [15:0] got;
      bit          stable;
      bit          early;
      int          end_cyc;
      int          start_cyc;
      prev_se = 1'b1;
      end_cyc = -1;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1 && prev_se && sreg_empty === 1'b0) begin
            start_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: frame started at cycle %0d, none queued", cyc);
            end else begin
               e = exp_q.pop_front();
               mon_busy = 1'b1;
               if (e.abort) begin
                  for (int c = 0; c < 5000 && rst !== 1'b1; c++) @(negedge clk);
                  check("abort_seen_reset", 32'(rst), 32'd1);
                  end_cyc = -1;
               end else begin
                  got    = '0;
                  stable = 1'b1;
                  early  = 1'b0;
                  first  = 1'b0;
                  for (int c = 0; c < e.nbits * e.bclk; c++) begin
                     if (c > 0) @(negedge clk);
                     if (c % e.bclk == 0) begin
                        first = tx;
                        got[c / e.bclk] = tx;
                     end else if (tx !== first) begin
                        stable = 1'b0;
                     end
                     if (sreg_empty !== 1'b0) early = 1'b1;
                  end
                  @(negedge clk);
                  check("frame_bits", 32'(got), 32'(e.bits));
                  check("bit_level_held", 32'(stable), 32'd1);
                  check("sreg_empty_low_whole_frame", 32'(early), 32'd0);
                  check("sreg_empty_after_frame", 32'(sreg_empty), 32'd1);
                  if (e.gap >= 0) check("idle_gap_cycles", 32'(start_cyc - end_cyc), 32'(e.gap));
                  end_cyc = cyc;
               end
               mon_busy = 1'b0;
            end
         end
         prev_se = sreg_empty;
      end
   end

   task automatic write_byte(input logic [7:0] d);
      @(posedge clk); #1;
      din = d;
      wr  = 1'b1;
      @(posedge clk); #1;
      wr  = 1'b0;
   endtask

   task automatic wait_se(input logic lvl, input int limit);
      int n = 0;
      while (sreg_empty !== lvl && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("wait_sreg_empty_level", 32'(sreg_empty), 32'(lvl));
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || mon_busy || sreg_empty !== 1'b1 || fifo_empty !== 1'b1)
             && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_within_budget", 32'(n < limit), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   task automatic set_cfg(input logic [15:0] div, input logic [2:0] len,
                          input logic [1:0] par, input logic st2);
      @(posedge clk); #1;
      cfg_div   = div;
      cfg_len   = len;
      cfg_par   = par;
      cfg_stop2 = st2;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "Simulation finished: %0d checks, %0d errors", checks, errors + 1);
   end

   initial begin : main
      logic [7:0] d;
      int         bad;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_baud_pulse", 32'(baud_pulse), 32'd0);
      check("rst_sreg_empty", 32'(sreg_empty), 32'd1);
      check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
      check("rst_fifo_full", 32'(fifo_full), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 8N1, div 1: 0xA5 -> start 0, data 1,0,1,0,0,1,0,1, stop 1.
      exp_q.push_back(mk_exp(16'b1_1010_0101_0, 10, 1, -1, 1'b0));
      write_byte(8'hA5);
      wait_idle(400);

      // 7 data bits of 0x55 (four ones) with parity variants.
      set_cfg(16'd1, 3'd6, 2'd2, 1'b0);
      exp_q.push_back(mk_exp(16'b1_0_1010101_0, 10, 1, -1, 1'b0));
      write_byte(8'h55);
      wait_idle(400);
      set_cfg(16'd1, 3'd6, 2'd1, 1'b0);
      exp_q.push_back(mk_exp(16'b1_1_1010101_0, 10, 1, -1, 1'b0));
      write_byte(8'h55);
      wait_idle(400);
      set_cfg(16'd1, 3'd6, 2'd3, 1'b0);
      exp_q.push_back(mk_exp(16'b1_1_1010101_0, 10, 1, -1, 1'b0));
      write_byte(8'h55);
      wait_idle(400);
      // Bit 7 of 0xD5 is not sent, so it must not flip even parity.
      set_cfg(16'd1, 3'd6, 2'd2, 1'b0);
      exp_q.push_back(mk_exp(16'b1_0_1010101_0, 10, 1, -1, 1'b0));
      write_byte(8'hD5);
      wait_idle(400);
      // cfg_len 2 is raised to 5 data bits: 0xE3 -> 1,1,0,0,0.
      set_cfg(16'd1, 3'd2, 2'd0, 1'b0);
      exp_q.push_back(mk_exp(16'b1_00011_0, 7, 1, -1, 1'b0));
      write_byte(8'hE3);
      wait_idle(400);

      // Break over data bits 0..3 of 0xFF; format changes mid-frame must not apply.
      set_cfg(16'd1, 3'd7, 2'd0, 1'b0);
      exp_q.push_back(mk_exp(16'b1_1111_0000_0, 10, 1, -1, 1'b0));
      write_byte(8'hFF);
      wait_se(1'b0, 100);
      repeat (16) @(posedge clk); #1;
      cfg_brk   = 1'b1;
      cfg_par   = 2'd3;
      cfg_stop2 = 1'b1;
      repeat (32) @(posedge clk);
      @(negedge clk);
      check("brk_tx_low", 32'(tx), 32'd0);
      repeat (32) @(posedge clk); #1;
      cfg_brk = 1'b0;
      wait_idle(400);

      // div 3, two stop bits, back-to-back 0x00 and 0xFF: one baud period of idle between.
      set_cfg(16'd3, 3'd7, 2'd0, 1'b1);
      exp_q.push_back(mk_exp(16'b11_0000_0000_0, 11, 3, -1, 1'b0));
      exp_q.push_back(mk_exp(16'b11_1111_1111_0, 11, 3, 3, 1'b0));
      @(posedge clk); #1;
      din = 8'h00;
      wr  = 1'b1;
      @(posedge clk); #1;
      din = 8'hFF;
      @(posedge clk); #1;
      wr  = 1'b0;
      wait_se(1'b0, 100);
      check("b2b_count_after_first_pop", 32'(fifo_count), 32'd1);
      wait_se(1'b1, 700);
      wait_se(1'b0, 100);
      check("b2b_fifo_empty_after_second_pop", 32'(fifo_empty), 32'd1);
      wait_idle(1200);

      // Fill with the generator stopped; the 17th write overflows and is never sent.
      set_cfg(16'd0, 3'd7, 2'd0, 1'b0);
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         d = 8'(i * 29 + 7);
         if (i == 15) begin
            check("fill_count_15", 32'(fifo_count), 32'd15);
            check("fill_not_full_15", 32'(fifo_full), 32'd0);
         end
         din = d;
         wr  = 1'b1;
         exp_q.push_back(mk_exp({6'b0, 1'b1, d, 1'b0}, 10, 1, (i == 0) ? -1 : 1, 1'b0));
         @(posedge clk); #1;
      end
      wr = 1'b0;
      @(negedge clk);
      check("fill_count_16", 32'(fifo_count), 32'd16);
      check("fill_full_16", 32'(fifo_full), 32'd1);
      check("fill_no_overflow_yet", 32'(overflow), 32'd0);
      @(posedge clk); #1;
      din = 8'hEE;
      wr  = 1'b1;
      @(posedge clk); #1;
      wr  = 1'b0;
      @(negedge clk);
      check("overflow_pulse", 32'(overflow), 32'd1);
      check("overflow_count_held", 32'(fifo_count), 32'd16);
      @(negedge clk);
      check("overflow_one_cycle", 32'(overflow), 32'd0);
      set_cfg(16'd1, 3'd7, 2'd0, 1'b0);
      wait_idle(16 * 170 + 200);

      // Flush wins over a simultaneous write; nothing is transmitted afterwards.
      set_cfg(16'd0, 3'd7, 2'd0, 1'b0);
      write_byte(8'h11);
      write_byte(8'h22);
      @(posedge clk); #1;
      din      = 8'h33;
      wr       = 1'b1;
      fifo_clr = 1'b1;
      @(posedge clk); #1;
      wr       = 1'b0;
      fifo_clr = 1'b0;
      @(negedge clk);
      check("clr_count", 32'(fifo_count), 32'd0);
      check("clr_empty", 32'(fifo_empty), 32'd1);
      set_cfg(16'd1, 3'd7, 2'd0, 1'b0);
      repeat (200) @(negedge clk);

      // Reset 50 clocks into a frame with a second byte still queued.
      exp_q.push_back(mk_exp(16'h0000, 0, 1, -1, 1'b1));
      write_byte(8'h3C);
      write_byte(8'h96);
      wait_se(1'b0, 100);
      repeat (50) @(posedge clk);
      @(negedge clk);
      check("pre_reset_queued", 32'(fifo_count), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midframe_rst_tx", 32'(tx), 32'd1);
      check("midframe_rst_sreg_empty", 32'(sreg_empty), 32'd1);
      check("midframe_rst_fifo_count", 32'(fifo_count), 32'd0);
      check("midframe_rst_fifo_empty", 32'(fifo_empty), 32'd1);
      check("midframe_rst_baud_pulse", 32'(baud_pulse), 32'd0);
      check("midframe_rst_overflow", 32'(overflow), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || sreg_empty !== 1'b1) bad++;
      end
      check("no_bits_after_reset", 32'(bad), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_gen.md
Name: uart_tx_fifo_gen

Overview:
Parametrised UART transmit channel with a transmit FIFO, a runtime baud divisor, runtime character format (data length, parity, stop bits) and break generation.
It is the next-generation transmit path of the 16550-style UART: it replaces the fixed 8N1 transmitter and exposes sreg_empty and baud_pulse for bench synchronisation.
Sits between the register-file write decode (THR writes) and the tx pin.

Parameters:
MAX_DATA_W, 8, maximum character length in bits (>=5).
FIFO_DEPTH, 16, transmit FIFO entries; power of two, >=2.
DIV_W, 16, baud divisor width.

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-high.
wr  in  1  push din into the FIFO (one entry per cycle while high).
din  in  MAX_DATA_W  character, LSB transmitted first.
fifo_clr  in  1  synchronous flush of FIFO contents; the frame in progress is unaffected.
cfg_div  in  DIV_W  baud divisor; 0 stops the baud generator.
cfg_len  in  $clog2(MAX_DATA_W)  data bits minus 1 (e.g. 7 = 8 bits); values below 4 are treated as 4.
cfg_par  in  2  parity: 0 none, 1 odd, 2 even, 3 stick (parity bit = 1).
cfg_stop2  in  1  0 = 1 stop bit, 1 = 2 stop bits.
cfg_brk  in  1  force tx low while high.
tx  out  1  serial line, idle high.
baud_pulse  out  1  one-cycle 16x-oversample tick.
sreg_empty  out  1  high when no frame is in progress.
fifo_empty  out  1  FIFO empty.
fifo_full  out  1  FIFO full.
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy.
overflow  out  1  one-cycle pulse when a write is dropped.

Behaviour:
Reset values: tx=1, baud_pulse=0, sreg_empty=1, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE, baud counter=0.
A reset asserted mid-frame drives tx=1 immediately and discards the FIFO.

Baud generator:
- Counter increments each clk; at count==cfg_div-1 it wraps to 0 and pulses baud_pulse.
- Period is therefore cfg_div cycles.
- cfg_div==0 holds the counter at 0 and baud_pulse at 0.
- A change to cfg_div takes effect at the next wrap or at a counter value >= the new divisor (counter resets to 0 with no pulse).

One bit time is 16 baud_pulses.

FIFO:
- wr with the FIFO not full: entry is written, and fifo_count increments on the next edge.
- wr with the FIFO full: data is dropped and overflow pulses on the next cycle, unless a pop occurs in the same cycle; in that case the write is accepted and fifo_count is unchanged.
- fifo_clr takes priority over a simultaneous wr and pop: count goes to 0 and the write is ignored.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when baud_pulse=1 and the FIFO is non-empty, pop the FIFO, latch the character and cfg_len/cfg_par/cfg_stop2, go to START.
  - sreg_empty drops and tx goes 0 on the following cycle.
- START: tx=0 for 16 pulses, then go to DATA.
- DATA: shift out cfg_len+1 bits, LSB first, 16 pulses each.
  - Then go to PARITY if par!=0, else STOP.
- PARITY: odd → bit = ~^data; even → ^data; stick → 1. Lasts 16 pulses.
  - Only the latched length participates in the parity computation.
- STOP: tx=1 for 16 pulses (32 pulses if stop2), then go to IDLE with sreg_empty=1.
  - Back-to-back frames: the next pop happens on the first IDLE baud_pulse, so there is no extra idle bit.

Configuration changes mid-frame affect only the next frame.

cfg_brk: tx=0 whenever it is high; the FSM keeps running unchanged. tx resumes the FSM value when cfg_brk deasserts.

Decomposition:
Shared package uart_pkg holds:
- the parity-mode constants PAR_NONE/ODD/EVEN/STICK;
- the FSM state enum;
- OVERSAMPLE=16.

One sub-module: uart_fifo_sync, a parametrised-width/depth synchronous FIFO providing count, full, empty, clear and the overflow pulse. Baud generator and FSM stay in the top module.

Test Plan:
- 8N1 at cfg_div=1, write 0xA5 → tx after start shows 1,0,1,0,0,1,0,1,1(stop) with each level held 16 clk. Frame is 160 clk, after which sreg_empty=1.
- cfg_len=6 (7 bits), cfg_par=2, write 0x55 → parity bit 0. With cfg_par=1 → parity bit 1. With cfg_par=3 → 1. Frame is 10 bits.
- cfg_div=0, write 17 bytes → fifo_full=1 and fifo_count=16 after the 16th write. overflow pulses once on the 17th; the 17th byte is never transmitted.
- cfg_div=3, cfg_stop2=1, write 0x00 and 0xFF back-to-back → first stop high for 96 clk, next start follows with no extra idle. fifo_empty=1 after the second pop.
- Assert rst 50 clk into a frame → tx=1 the same cycle. All outputs take their reset values and no bits follow.
- cfg_brk=1 during frame data bits → tx=0 throughout. On deassert, tx follows the FSM value and sreg_empty timing is unchanged from a frame without break.
